// File: rtl/isr_autopush.sv
// Input shift register with PUSH/PUSH IFFULL, autopush and a one-entry output slot toward the RX FIFO.
// Define ISR_AUTOPUSH_EN to enable autopush; otherwise auto_push/thresh are ignored and IFFULL compares against W.
module isr_autopush #(
    parameter  int W  = 32,
    localparam int SW = $clog2(W),
    localparam int CW = SW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          penable,
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] shift,
    input  logic          dir,
    input  logic          do_shift,
    input  logic          do_push,
    input  logic          push_block,
    input  logic          push_iffull,
    input  logic          set,
    input  logic [CW-1:0] set_count,
    input  logic          auto_push,
    input  logic [SW-1:0] thresh,
    input  logic          push_ready,
    output logic          push_valid,
    output logic [W-1:0]  push_data,
    output logic          stall,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] shift_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slotState_e;

    slotState_e    state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  data_q, data_d;

    logic          slotFree;
    logic          loadSlot;
    logic [W-1:0]  loadData;
    logic [CW-1:0] nAmt;
    logic [CW-1:0] thr;
    logic [W-1:0]  inBits;
    logic [W-1:0]  shiftedVal;
    logic [CW:0]   newCountWide;
    logic [CW-1:0] newCount;
    logic [CW-1:0] setCountSat;
    logic          autoPushHit;

    // A count of 0 on the shift input means a full-width shift.
    assign nAmt   = (shift == '0) ? CW'(W) : {1'b0, shift};
    assign inBits = din & ~({W{1'b1}} << nAmt);

    // Shifting by the full width empties the old contents, leaving only din.
    always_comb begin
        if (dir) begin
            shiftedVal = (shift_q >> nAmt) | (inBits << (CW'(W) - nAmt));
        end else begin
            shiftedVal = (shift_q << nAmt) | inBits;
        end
    end

    assign newCountWide = {1'b0, count_q} + {1'b0, nAmt};
    assign newCount     = (newCountWide > (CW+1)'(W)) ? CW'(W) : newCountWide[CW-1:0];
    assign setCountSat  = (set_count > CW'(W)) ? CW'(W) : set_count;

`ifdef ISR_AUTOPUSH_EN
    assign thr         = (thresh == '0) ? CW'(W) : {1'b0, thresh};
    assign autoPushHit = auto_push && (newCount >= thr);
`else
    logic unused_autopush;
    assign thr             = CW'(W);
    assign autoPushHit     = 1'b0;
    assign unused_autopush = auto_push ^ (^thresh);
`endif

    assign slotFree = (state_q == EMPTY) || push_ready;

    // Instruction decode: set beats push beats IN; a blocked event stalls with no state change.
    always_comb begin
        shift_d  = shift_q;
        count_d  = count_q;
        loadSlot = 1'b0;
        loadData = shift_q;
        stall    = 1'b0;
        if (penable) begin
            if (set) begin
                shift_d = din;
                count_d = setCountSat;
            end else if (do_push) begin
                if (push_iffull && (count_q < thr)) begin
                    shift_d = shift_q;
                end else if (slotFree) begin
                    loadSlot = 1'b1;
                    shift_d  = '0;
                    count_d  = '0;
                end else if (push_block) begin
                    stall = 1'b1;
                end else begin
                    shift_d = '0;
                    count_d = '0;
                end
            end else if (do_shift) begin
                if (autoPushHit) begin
                    if (slotFree) begin
                        loadSlot = 1'b1;
                        loadData = shiftedVal;
                        shift_d  = '0;
                        count_d  = '0;
                    end else begin
                        stall = 1'b1;
                    end
                end else begin
                    shift_d = shiftedVal;
                    count_d = newCount;
                end
            end
        end
    end

    // Slot: a load keeps it FULL even while the previous word is handed off.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (loadSlot) begin
            state_d = FULL;
            data_d  = loadData;
        end else if ((state_q == FULL) && push_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            shift_q <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign push_valid  = (state_q == FULL);
    assign push_data   = data_q;
    assign dout        = shift_q;
    assign shift_count = count_q;

endmodule

// File: tb/tb_isr_autopush.sv
// Directed self-checking bench for isr_autopush (W=32); expected values are hand-computed constants.
module tb_isr_autopush;

    localparam int W  = 32;
    localparam int SW = 5;
    localparam int CW = 6;

    logic          clk;
    logic          reset_n;
    logic          penable;
    logic [W-1:0]  din;
    logic [SW-1:0] shift;
    logic          dir;
    logic          do_shift;
    logic          do_push;
    logic          push_block;
    logic          push_iffull;
    logic          set;
    logic [CW-1:0] set_count;
    logic          auto_push;
    logic [SW-1:0] thresh;
    logic          push_ready;
    logic          push_valid;
    logic [W-1:0]  push_data;
    logic          stall;
    logic [W-1:0]  dout;
    logic [CW-1:0] shift_count;

    int checkCount = 0;
    int failCount  = 0;

    isr_autopush #(.W(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .penable     (penable),
        .din         (din),
        .shift       (shift),
        .dir         (dir),
        .do_shift    (do_shift),
        .do_push     (do_push),
        .push_block  (push_block),
        .push_iffull (push_iffull),
        .set         (set),
        .set_count   (set_count),
        .auto_push   (auto_push),
        .thresh      (thresh),
        .push_ready  (push_ready),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .stall       (stall),
        .dout        (dout),
        .shift_count (shift_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic doSetV, input logic doPushV, input logic doShiftV,
                                 input logic [W-1:0] dinV);
        set      = doSetV;
        do_push  = doPushV;
        do_shift = doShiftV;
        din      = dinV;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b1;
        penable     = 1'b0;
        din         = '0;
        shift       = '0;
        dir         = 1'b0;
        do_shift    = 1'b0;
        do_push     = 1'b0;
        push_block  = 1'b0;
        push_iffull = 1'b0;
        set         = 1'b0;
        set_count   = '0;
        auto_push   = 1'b0;
        thresh      = '0;
        push_ready  = 1'b0;

        #3 reset_n = 1'b0;
        #2;
        checkOutput("reset dout",  dout, 32'h0);
        checkOutput("reset count", 32'(shift_count), 32'd0);
        checkOutput("reset valid", 32'(push_valid), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // penable low: instructions ignored
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFF);
        shift = 5'd8;
        tick();
        checkOutput("penable0 dout", dout, 32'h0);

        // Left IN, n=8, five times
        penable = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA5);
        tick();
        checkOutput("left1 dout",  dout, 32'h000000A5);
        checkOutput("left1 count", 32'(shift_count), 32'd8);
        repeat (4) tick();
        checkOutput("left5 dout",  dout, 32'hA5A5A5A5);
        checkOutput("left5 count", 32'(shift_count), 32'd32);

        // PUSH into empty slot, FIFO ready
        push_ready = 1'b1;
        push_block = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("push1 valid", 32'(push_valid), 32'd1);
        checkOutput("push1 data",  push_data, 32'hA5A5A5A5);
        checkOutput("push1 dout",  dout, 32'h0);
        checkOutput("push1 count", 32'(shift_count), 32'd0);

        // Right IN full width; slot drains on the same edge
        dir   = 1'b1;
        shift = 5'd0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        tick();
        checkOutput("right32 dout",  dout, 32'hDEADBEEF);
        checkOutput("right32 count", 32'(shift_count), 32'd32);
        checkOutput("drain valid",   32'(push_valid), 32'd0);

        shift = 5'd4;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFFFFF3);
        tick();
        checkOutput("right4 dout",  dout, 32'h3DEADBEE);
        checkOutput("right4 count", 32'(shift_count), 32'd32);

        // set with count saturation, then a normal set
        push_ready = 1'b0;
        set_count  = 6'd40;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h12345678);
        tick();
        checkOutput("setsat dout",  dout, 32'h12345678);
        checkOutput("setsat count", 32'(shift_count), 32'd32);
        set_count = 6'd8;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h55);
        tick();
        checkOutput("set8 count", 32'(shift_count), 32'd8);

        // PUSH IFFULL with count below threshold: no-op
        thresh      = 5'd16;
        push_iffull = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("iffull stall", 32'(stall), 32'd0);
        tick();
        checkOutput("iffull dout",  dout, 32'h55);
        checkOutput("iffull count", 32'(shift_count), 32'd8);
        checkOutput("iffull valid", 32'(push_valid), 32'd0);

        // Blocking PUSH into empty slot with FIFO not ready
        push_iffull = 1'b0;
        push_block  = 1'b1;
        tick();
        checkOutput("pushE valid", 32'(push_valid), 32'd1);
        checkOutput("pushE data",  push_data, 32'h55);
        checkOutput("pushE dout",  dout, 32'h0);

        // Blocking PUSH against a full slot stalls until push_ready
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h77);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("block stall", 32'(stall), 32'd1);
            tick();
            checkOutput("block dout", dout, 32'h77);
            checkOutput("block data", push_data, 32'h55);
        end
        push_ready = 1'b1;
        #1;
        checkOutput("unblock stall", 32'(stall), 32'd0);
        tick();
        checkOutput("unblock data",  push_data, 32'h77);
        checkOutput("unblock valid", 32'(push_valid), 32'd1);
        checkOutput("unblock dout",  dout, 32'h0);

        // Noblock PUSH against a full slot drops the ISR word
        push_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h55);
        tick();
        push_block = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("noblock stall", 32'(stall), 32'd0);
        tick();
        checkOutput("noblock dout",  dout, 32'h0);
        checkOutput("noblock count", 32'(shift_count), 32'd0);
        checkOutput("noblock data",  push_data, 32'h77);
        checkOutput("noblock valid", 32'(push_valid), 32'd1);

        // Asynchronous reset while the slot is full
        set_count = 6'd8;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h99);
        tick();
        penable = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("areset valid", 32'(push_valid), 32'd0);
        checkOutput("areset dout",  dout, 32'h0);
        checkOutput("areset count", 32'(shift_count), 32'd0);
        checkOutput("areset stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Autopush at threshold 16 (ignored when the feature is compiled out)
        penable    = 1'b1;
        push_ready = 1'b1;
        auto_push  = 1'b1;
        thresh     = 5'd16;
        shift      = 5'd8;
        dir        = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h12);
        tick();
        checkOutput("ap1 dout",  dout, 32'h12);
        checkOutput("ap1 valid", 32'(push_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h34);
        tick();
`ifdef ISR_AUTOPUSH_EN
        checkOutput("ap2 data",  push_data, 32'h00001234);
        checkOutput("ap2 valid", 32'(push_valid), 32'd1);
        checkOutput("ap2 dout",  dout, 32'h0);
        checkOutput("ap2 count", 32'(shift_count), 32'd0);
`else
        checkOutput("ap2 valid", 32'(push_valid), 32'd0);
        checkOutput("ap2 dout",  dout, 32'h00001234);
        checkOutput("ap2 count", 32'(shift_count), 32'd16);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/isr_autopush.md
# isr_autopush

Parametrised input shift register (ISR) for a PIO state machine. It adds configurable data width, a push threshold with autopush, PUSH/PUSH IFFULL instructions with block/noblock semantics, and a one-entry output slot with a valid/ready handshake toward the RX FIFO. It sits between the state-machine execution unit and the RX FIFO. It generates its own stall request, so the execution unit can hold a FIFO-blocked instruction.

## Interface
- `W`, 32: shift-register width; power of two, at least 8. Derived widths: `SW` = $clog2(W); `CW` = SW+1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `penable`  in  1  state-machine enable; instruction inputs are ignored when low.
- `din`  in  W  IN source data; the low `n` bits are used.
- `shift`  in  SW  IN bit count; 0 encodes W. Denoted `n` below.
- `dir`  in  1  1 = shift right; 0 = shift left.
- `do_shift`  in  1  execute IN.
- `do_push`  in  1  execute PUSH.
- `push_block`  in  1  the PUSH blocks when the slot is busy.
- `push_iffull`  in  1  the PUSH is a no-op unless `count >= thr`.
- `set`  in  1  load ISR (MOV ISR, ...).
- `set_count`  in  CW  count loaded with `set`.
- `auto_push`  in  1  autopush enable.
- `thresh`  in  SW  push threshold; 0 encodes W. Denoted `thr` below.
- `push_ready`  in  1  RX FIFO can accept data.
- `push_valid`  out  1  slot holds a word.
- `push_data`  out  W  slot word.
- `stall`  out  1  combinational; the current instruction cannot complete.
- `dout`  out  W  ISR contents.
- `shift_count`  out  CW  ISR fill count, 0..W.

## Operation
- Slot FSM:
  - States: EMPTY (`push_valid`=0) and FULL (`push_valid`=1).
  - `slot_free` = EMPTY, or FULL with `push_ready`=1.
  - FULL to EMPTY when `push_valid && push_ready` and no new load in the same cycle. A load on that edge keeps the state FULL with the new data.
  - Handshake completion is independent of `penable`.
- Priority among instruction inputs: `set`, then `do_push`, then `do_shift`. Instruction inputs act only when `penable`=1 and `stall`=0.
- `set`:
  - `shift_reg` <= `din`.
  - `count` <= `set_count`, saturated to W.
- IN, left shift: `shift_reg` <= (`shift_reg` << n) | `din`[n-1:0].
- IN, right shift: `shift_reg` <= (`shift_reg` >> n) | (`din`[n-1:0] << (W-n)).
- IN count update: `new_count` = min(`count`+n, W), computed at CW+1 bits.
- Autopush, applied to IN when `auto_push` and `new_count >= thr`:
  - This is a push-required event with the new shift value as data.
  - If `slot_free`: the slot loads the new value, and `shift_reg` and `count` clear to 0.
  - Otherwise: `stall`=1 and no state changes.
- PUSH:
  - With `push_iffull` and `count < thr`: no-op, no stall.
  - Otherwise, if `slot_free`: the slot loads `shift_reg`.
  - Otherwise, if `push_block`: `stall`=1 and no state changes.
  - Otherwise (noblock, slot busy): the data is dropped.
  - In every case except the no-op and the stall, ISR and `count` clear.
- `stall` = `penable` && (blocking push-required event) && !`slot_free`.
- `shift_count` = `count`. There is no special encoding.

## Timing
- Reset: asynchronous assertion. `shift_reg`, `count`, `push_data` and `push_valid` go to 0; therefore `dout`=0, `shift_count`=0 and `stall`=0.
- A reset during FULL discards the word.
- ISR update latency: 1 cycle; `dout` changes on the edge that ends the instruction cycle.
- `push_valid` rises on the edge after a push-required event.
- One push per cycle is sustained when `push_ready` is held at 1.
- With `push_ready` low while the slot is FULL, a blocking push holds `stall`=1 every cycle. It completes in the cycle `push_ready` rises.

## Configuration
- `ISR_AUTOPUSH_EN`:
  - Defined: autopush as described above.
  - Undefined: the `auto_push` and `thresh` inputs are ignored and IN never pushes. PUSH IFFULL compares against W.

## Test plan
- Reset: pulse `reset_n` low while `push_valid`=1 -> `push_valid`=0, `dout`=0, `shift_count`=0, `stall`=0 immediately.
- Left IN, W=32: `n`=8, `din`=0xA5 five times -> `dout`=0xA5A5A5A5, `shift_count`=32 (saturated).
- Right IN: `shift`=0, `din`=0xDEADBEEF -> `dout`=0xDEADBEEF, `shift_count`=32.
- Autopush: `thresh`=16, `n`=8, left, `din`=0x12 then 0x34, `push_ready`=1 -> `push_data`=0x00001234 and `push_valid`=1 on the next edge, `dout`=0, `shift_count`=0.
- Blocking PUSH: slot FULL, `push_ready`=0 for 3 cycles -> `stall`=1 for 3 cycles and `dout` held. When `push_ready`=1, the old word transfers and `push_data` becomes the ISR value on the same edge.
- Noblock PUSH: slot FULL, `push_ready`=0, ISR=0x55 -> `stall`=0, `dout`=0, and `push_data` keeps the old word (0x55 dropped).
